// File: rtl/mem_access_if.sv
// Request/response and memory-side signals of the load/store access unit.
// The master side is the pipeline MEM stage plus data memory; the slave side is the unit.
interface mem_access_if;
    logic        req_valid;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        output mem_resp, mem_rdata,
        input  stall, resp_valid, resp_rdata, err,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        input  mem_resp, mem_rdata,
        output stall, resp_valid, resp_rdata, err,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store unit: validates, aligns and issues one memory access per
// instruction, stalling the pipeline until the memory completes.
module mem_access_unit (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic        lat_load;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_offset;

    logic        one_op;
    logic        both_op;
    logic        load_legal;
    logic        store_legal;
    logic        legal;
    logic        aligned;
    logic        req_ok;
    logic [1:0]  offset;

    assign offset = bus.req_addr[1:0];

    // Request qualification: exactly one op, known funct3, naturally aligned.
    always_comb begin
        one_op      = bus.req_load ^ bus.req_store;
        both_op     = bus.req_load & bus.req_store;
        load_legal  = 1'b0;
        store_legal = (bus.req_funct3[2] == 1'b0) && (bus.req_funct3[1:0] != 2'b11);
        aligned     = 1'b1;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_legal = 1'b1;
            default:                                load_legal = 1'b0;
        endcase
        case (bus.req_funct3[1:0])
            2'b01:   aligned = ~offset[0];
            2'b10:   aligned = (offset == 2'b00);
            default: aligned = 1'b1;
        endcase
        legal  = one_op & (bus.req_load ? load_legal : store_legal);
        req_ok = bus.req_valid & legal & aligned;
    end

    assign bus.stall = req_ok & (state != DONE);
    assign bus.err   = ~rst & (state == IDLE) & bus.req_valid
                     & (both_op | (one_op & ~(legal & aligned)));

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Control FSM with registered memory strobes and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            lat_load            <= 1'b0;
            lat_funct3          <= 3'b000;
            lat_offset          <= 2'b00;
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.mem_address     <= 32'h0;
            bus.mem_wdata       <= 32'h0;
            bus.mem_byte_enable <= 4'h0;
            bus.resp_valid      <= 1'b0;
            bus.resp_rdata      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        lat_load            <= bus.req_load;
                        lat_funct3          <= bus.req_funct3;
                        lat_offset          <= offset;
                        bus.mem_read        <= bus.req_load;
                        bus.mem_write       <= bus.req_store;
                        bus.mem_address     <= {bus.req_addr[31:2], 2'b00};
                        bus.mem_wdata       <= bus.req_store ? store_data(bus.req_funct3, bus.req_wdata)
                                                             : 32'h0;
                        bus.mem_byte_enable <= bus.req_load ? 4'b1111
                                                            : store_mask(bus.req_funct3, offset);
                        state               <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_resp) begin
                        bus.mem_read   <= 1'b0;
                        bus.mem_write  <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= lat_load ? load_extract(lat_funct3, lat_offset, bus.mem_rdata)
                                                   : 32'h0;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    bus.resp_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, error cases, reset and back-to-back.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst;

    mem_access_if bus();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        o_accept_stall, o_early_resp, o_rd, o_wr, o_hold;
    logic        o_resp, o_stall_done, o_strobe_done, o_resp_after;
    logic [31:0] o_addr, o_wdata, o_rdata, o_rdata_after;
    logic [3:0]  o_be;

    typedef struct packed {
        logic        l;
        logic        s;
        logic [2:0]  f3;
        logic [31:0] a;
    } err_vec_t;

    err_vec_t evec [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic l, input logic s, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] w);
        bus.req_valid  = 1'b1;
        bus.req_load   = l;
        bus.req_store  = s;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = w;
    endtask

    task automatic clear_req();
        bus.req_valid  = 1'b0;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
    endtask

    // Drives one full access; memory answers 'delay' cycles after the strobe appears.
    task automatic run_access(input logic l, input logic s, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] w,
                              input logic [31:0] rd, input int delay);
        set_req(l, s, f3, a, w);
        bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        o_accept_stall = bus.stall;
        tick();
        o_early_resp = bus.resp_valid;
        o_rd    = bus.mem_read;
        o_wr    = bus.mem_write;
        o_addr  = bus.mem_address;
        o_wdata = bus.mem_wdata;
        o_be    = bus.mem_byte_enable;
        o_hold  = 1'b1;
        for (int i = 0; i < delay; i++) begin
            if (bus.stall !== 1'b1 || bus.mem_read !== l || bus.mem_write !== s
                || bus.mem_address !== o_addr || bus.resp_valid !== 1'b0) o_hold = 1'b0;
            tick();
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rd;
        #1;
        if (bus.stall !== 1'b1 || bus.mem_read !== l || bus.mem_write !== s) o_hold = 1'b0;
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        o_resp        = bus.resp_valid;
        o_rdata       = bus.resp_rdata;
        o_stall_done  = bus.stall;
        o_strobe_done = bus.mem_read | bus.mem_write;
        clear_req();
        tick();
        o_resp_after  = bus.resp_valid;
        o_rdata_after = bus.resp_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_req();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        set_req(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0);
        #1;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.err); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_strobes: got %b%b expected 00", bus.mem_read, bus.mem_write); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h expected 0", bus.resp_rdata); end
        checks++; if (bus.mem_address !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_addr_data: got %h/%h expected 0/0", bus.mem_address, bus.mem_wdata); end
        checks++; if (bus.mem_byte_enable !== 4'h0) begin errors++; $display("FAIL rst_be: got %b expected 0000", bus.mem_byte_enable); end
        clear_req();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_byte();
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 2);
        checks++; if (o_accept_stall !== 1'b1) begin errors++; $display("FAIL lb_accept_stall: got %b expected 1", o_accept_stall); end
        checks++; if (o_rd !== 1'b1 || o_wr !== 1'b0) begin errors++; $display("FAIL lb_strobe: got rd=%b wr=%b expected rd=1 wr=0", o_rd, o_wr); end
        checks++; if (o_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h expected 00001000", o_addr); end
        checks++; if (o_be !== 4'b1111) begin errors++; $display("FAIL lb_be: got %b expected 1111", o_be); end
        checks++; if (o_hold !== 1'b1) begin errors++; $display("FAIL lb_hold: got %b expected 1", o_hold); end
        checks++; if (o_resp !== 1'b1) begin errors++; $display("FAIL lb_resp: got %b expected 1", o_resp); end
        checks++; if (o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", o_rdata); end
        checks++; if (o_stall_done !== 1'b0) begin errors++; $display("FAIL lb_done_stall: got %b expected 0", o_stall_done); end
        checks++; if (o_strobe_done !== 1'b0) begin errors++; $display("FAIL lb_strobe_drop: got %b expected 0", o_strobe_done); end
        checks++; if (o_resp_after !== 1'b0) begin errors++; $display("FAIL lb_resp_pulse: got %b expected 0", o_resp_after); end
        checks++; if (o_rdata_after !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata_hold: got %h expected ffffff80", o_rdata_after); end
    endtask

    task automatic test_load_ext();
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 1);
        checks++; if (o_resp !== 1'b1 || o_rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_rdata: got %b/%h expected 1/00009abc", o_resp, o_rdata); end
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 1);
        checks++; if (o_resp !== 1'b1 || o_rdata !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh_rdata: got %b/%h expected 1/ffff9abc", o_resp, o_rdata); end
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0, 32'h0001_8001, 0);
        checks++; if (o_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_low_rdata: got %h expected ffff8001", o_rdata); end
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_5001, 32'h0, 32'h1122_F344, 0);
        checks++; if (o_rdata !== 32'h0000_00F3) begin errors++; $display("FAIL lbu_rdata: got %h expected 000000f3", o_rdata); end
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 1);
        checks++; if (o_rdata !== 32'hCAFE_F00D || o_addr !== 32'h0000_4004) begin errors++; $display("FAIL lw_rdata: got %h@%h expected cafef00d@00004004", o_rdata, o_addr); end
    endtask

    task automatic test_store();
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h1234_5678, 1);
        checks++; if (o_wr !== 1'b1 || o_rd !== 1'b0) begin errors++; $display("FAIL sb_strobe: got rd=%b wr=%b expected rd=0 wr=1", o_rd, o_wr); end
        checks++; if (o_be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b expected 0010", o_be); end
        checks++; if (o_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o_wdata); end
        checks++; if (o_addr !== 32'h0000_3000) begin errors++; $display("FAIL sb_addr: got %h expected 00003000", o_addr); end
        checks++; if (o_resp !== 1'b1 || o_rdata !== 32'h0) begin errors++; $display("FAIL sb_resp: got %b/%h expected 1/00000000", o_resp, o_rdata); end
        checks++; if (o_hold !== 1'b1) begin errors++; $display("FAIL sb_hold: got %b expected 1", o_hold); end
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_BEEF, 32'h0, 0);
        checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", o_be); end
        checks++; if (o_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h expected beefbeef", o_wdata); end
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_3003, 32'h0000_003C, 32'h0, 0);
        checks++; if (o_be !== 4'b1000 || o_wdata !== 32'h3C3C_3C3C) begin errors++; $display("FAIL sb3_be_wdata: got %b/%h expected 1000/3c3c3c3c", o_be, o_wdata); end
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_3004, 32'h0123_4567, 32'h0, 2);
        checks++; if (o_be !== 4'b1111 || o_wdata !== 32'h0123_4567 || o_addr !== 32'h0000_3004) begin errors++; $display("FAIL sw_bus: got %b/%h@%h expected 1111/01234567@00003004", o_be, o_wdata, o_addr); end
    endtask

    task automatic test_errors();
        evec = '{
            '{1'b1, 1'b0, 3'b010, 32'h0000_4002},
            '{1'b1, 1'b0, 3'b011, 32'h0000_4000},
            '{1'b1, 1'b0, 3'b101, 32'h0000_4001},
            '{1'b0, 1'b1, 3'b001, 32'h0000_3001},
            '{1'b0, 1'b1, 3'b010, 32'h0000_3002},
            '{1'b0, 1'b1, 3'b100, 32'h0000_3000},
            '{1'b1, 1'b1, 3'b010, 32'h0000_3000}
        };
        for (int i = 0; i < 7; i++) begin
            set_req(evec[i].l, evec[i].s, evec[i].f3, evec[i].a, 32'h5555_AAAA);
            #1;
            checks++; if (bus.err !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL err_vec%0d: got err=%b stall=%b expected err=1 stall=0", i, bus.err, bus.stall); end
            tick();
            checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL err_nostrobe%0d: got rd=%b wr=%b expected 0 0", i, bus.mem_read, bus.mem_write); end
            clear_req();
            #1;
            checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_pulse%0d: got %b expected 0", i, bus.err); end
            tick();
        end
        bus.req_valid = 1'b1;
        #1;
        checks++; if (bus.err !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL err_noop: got err=%b stall=%b expected 0 0", bus.err, bus.stall); end
        clear_req();
        tick();
    endtask

    task automatic test_reset_mid_access();
        set_req(1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'h55AA_55AA);
        tick();
        checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_write: got %b expected 1", bus.mem_write); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_address !== 32'h0 || bus.mem_byte_enable !== 4'h0) begin errors++; $display("FAIL rstmid_async: got wr=%b addr=%h be=%b expected 0 0 0", bus.mem_write, bus.mem_address, bus.mem_byte_enable); end
        #1;
        rst = 1'b0;
        clear_req();
        bus.mem_resp = 1'b1;
        tick();
        o_resp = bus.resp_valid;
        tick();
        o_resp = o_resp | bus.resp_valid;
        checks++; if (o_resp !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL rstmid_noresp: got resp=%b wr=%b expected 0 0", o_resp, bus.mem_write); end
        bus.mem_resp = 1'b0;
        tick();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 0);
        checks++; if (o_rd !== 1'b1 || o_resp !== 1'b1 || o_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL rstmid_recover: got rd=%b resp=%b rdata=%h expected 1 1 13579bdf", o_rd, o_resp, o_rdata); end
    endtask

    task automatic test_back_to_back();
        bus.mem_resp = 1'b1;
        tick();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_ignored: got %b expected 0", bus.resp_valid); end
        bus.mem_resp = 1'b0;
        tick();
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_7000, 32'h0, 32'h0000_00FE, 0);
        checks++; if (o_early_resp !== 1'b0 || o_resp !== 1'b1) begin errors++; $display("FAIL b2b_latency: got early=%b resp=%b expected 0 1", o_early_resp, o_resp); end
        checks++; if (o_rdata !== 32'h0000_00FE) begin errors++; $display("FAIL b2b_rdata0: got %h expected 000000fe", o_rdata); end
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_7002, 32'h0, 32'h0080_0000, 0);
        checks++; if (o_accept_stall !== 1'b1 || o_rd !== 1'b1) begin errors++; $display("FAIL b2b_accept: got stall=%b rd=%b expected 1 1", o_accept_stall, o_rd); end
        checks++; if (o_resp !== 1'b1 || o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL b2b_rdata1: got %b/%h expected 1/ffffff80", o_resp, o_rdata); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_ext();
        test_store();
        test_errors();
        test_reset_mid_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
